// File: rtl/if_spi_slave.sv
// Mode-0 SPI slave: MOSI words are deserialised into an RX FIFO, TX FIFO words are serialised onto MISO.
// All SPI pins are oversampled in the clk domain.
module if_spi_slave #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    RX_DEPTH   = 128,
    parameter int                    TX_DEPTH   = 128,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  cs,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_ena,
    output logic                  tx_full,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  have_msg,
    output logic [7:0]            len,
    output logic                  frame_err,
    output logic                  overflow,
    output logic [1:0]            dbg_state
);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int CW  = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, ABORT = 2'd2} state_t;
    state_t state;
    assign dbg_state = state;

    logic cs_meta, cs_sync, cs_d;
    logic sclk_meta, sclk_sync, sclk_d;
    logic mosi_meta, mosi_sync;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_d      <= 1'b1;
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_d    <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            cs_meta   <= cs;
            cs_sync   <= cs_meta;
            cs_d      <= cs_sync;
            sclk_meta <= sclk;
            sclk_sync <= sclk_meta;
            sclk_d    <= sclk_sync;
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
        end
    end

    logic cs_fall, cs_rise, sclk_rise, sclk_fall;
    assign cs_fall   =  cs_d & ~cs_sync;
    assign cs_rise   = ~cs_d &  cs_sync;
    assign sclk_rise = ~sclk_d &  sclk_sync;
    assign sclk_fall =  sclk_d & ~sclk_sync;

    // TX FIFO: pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [TAW:0]          tx_wr_ptr, tx_rd_ptr;
    logic                  tx_empty;
    logic [DATA_WIDTH-1:0] tx_next;

    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full  = (tx_wr_ptr[TAW] != tx_rd_ptr[TAW]) &&
                      (tx_wr_ptr[TAW-1:0] == tx_rd_ptr[TAW-1:0]);
    assign tx_next  = tx_empty ? FILL_WORD : tx_mem[tx_rd_ptr[TAW-1:0]];

    always_ff @(posedge clk) begin
        if (in_ena && !tx_full)
            tx_mem[tx_wr_ptr[TAW-1:0]] <= in_data;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            tx_wr_ptr <= '0;
        else if (in_ena && !tx_full)
            tx_wr_ptr <= tx_wr_ptr + (TAW+1)'(1);
    end

    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] tx_sh, hold;
    logic [DATA_WIDTH-2:0] rx_sh;
    logic                  word_done, cs_pend;
    logic                  rx_wr_en;
    logic [DATA_WIDTH-1:0] rx_wr_data;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            tx_sh      <= '0;
            hold       <= '0;
            rx_sh      <= '0;
            word_done  <= 1'b0;
            cs_pend    <= 1'b0;
            miso       <= 1'b0;
            frame_err  <= 1'b0;
            rx_wr_en   <= 1'b0;
            rx_wr_data <= '0;
            tx_rd_ptr  <= '0;
        end else begin
            frame_err <= 1'b0;
            rx_wr_en  <= 1'b0;
            case (state)
                IDLE: begin
                    miso      <= 1'b0;
                    bit_cnt   <= '0;
                    word_done <= 1'b0;
                    cs_pend   <= 1'b0;
                    if (cs_fall || cs_pend) begin
                        tx_sh <= tx_next;
                        miso  <= tx_next[DATA_WIDTH-1];
                        if (!tx_empty) tx_rd_ptr <= tx_rd_ptr + (TAW+1)'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // cs release takes priority over any sclk edge seen in the same cycle.
                    if (cs_rise) begin
                        miso      <= 1'b0;
                        bit_cnt   <= '0;
                        word_done <= 1'b0;
                        if (bit_cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ABORT;
                        end
                    end else if (sclk_rise) begin
                        rx_sh <= {rx_sh[DATA_WIDTH-3:0], mosi_sync};
                        if (bit_cnt == CW'(DATA_WIDTH-1)) begin
                            bit_cnt    <= '0;
                            rx_wr_en   <= 1'b1;
                            rx_wr_data <= {rx_sh, mosi_sync};
                            hold       <= tx_next;
                            word_done  <= 1'b1;
                            if (!tx_empty) tx_rd_ptr <= tx_rd_ptr + (TAW+1)'(1);
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end else if (sclk_fall) begin
                        if (word_done) begin
                            tx_sh     <= hold;
                            miso      <= hold[DATA_WIDTH-1];
                            word_done <= 1'b0;
                        end else begin
                            tx_sh <= tx_sh << 1;
                            miso  <= tx_sh[DATA_WIDTH-2];
                        end
                    end
                end
                ABORT: begin
                    cs_pend <= cs_fall;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RX FIFO: a completed word is written the cycle after its last sclk rise.
    logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [RAW-1:0]        rx_wr_ptr, rx_rd_ptr;
    logic                  rx_full, rx_do_wr, rx_do_rd;

    assign rx_full  = (len == 8'(RX_DEPTH));
    assign rx_do_wr = rx_wr_en && !rx_full;
    assign rx_do_rd = rd_req && (len != 8'd0);
    assign have_msg = (len != 8'd0);

    always_ff @(posedge clk) begin
        if (rx_do_wr)
            rx_mem[rx_wr_ptr] <= rx_wr_data;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            len       <= '0;
            out_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (rx_wr_en && rx_full) overflow <= 1'b1;
            if (rx_do_wr) rx_wr_ptr <= rx_wr_ptr + RAW'(1);
            if (rx_do_rd) begin
                out_data  <= rx_mem[rx_rd_ptr];
                rx_rd_ptr <= rx_rd_ptr + RAW'(1);
            end
            case ({rx_do_wr, rx_do_rd})
                2'b10:   len <= len + 8'd1;
                2'b01:   len <= len - 8'd1;
                default: len <= len;
            endcase
        end
    end
endmodule

// File: doc/if_spi_slave.md
Name: if_spi_slave

Overview:
- SPI slave (responder) front end: lets an external SPI master, or our own SPI master on a loopback bench, exchange 16-bit words with the fabric.
- Oversamples cs/sclk/mosi in the clk domain and deserialises MOSI words into an RX FIFO.
- Serialises response words from a TX FIFO onto MISO.
- Mode 0 (CPOL=0, CPHA=0), MSB first; pairs with the team's 16-bit master configuration.

Parameters:
- DATA_WIDTH, 16, SPI word length in bits.
- RX_DEPTH, 128, RX FIFO depth in words (power of 2, ≤128).
- TX_DEPTH, 128, TX FIFO depth in words (power of 2, ≤128).
- FILL_WORD, 16'h0000, word shifted out when the TX FIFO is empty.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- cs  in  1  SPI chip select, active-low, asynchronous to clk
- sclk  in  1  SPI clock, asynchronous to clk, f_sclk ≤ f_clk/8
- mosi  in  1  SPI data from master
- miso  out  1  SPI data to master
- in_data  in  DATA_WIDTH  TX word to enqueue
- in_ena  in  1  TX write strobe
- tx_full  out  1  TX FIFO full
- rd_req  in  1  RX FIFO read strobe
- out_data  out  DATA_WIDTH  RX word; valid the cycle after rd_req (non-show-ahead)
- have_msg  out  1  RX FIFO not empty
- len  out  8  RX FIFO words used
- frame_err  out  1  one-clk pulse: cs deasserted mid-word
- overflow  out  1  sticky: RX word dropped because the RX FIFO was full

Behaviour:
- Reset: all outputs 0. miso=0, len=0, have_msg=0, tx_full=0, overflow=0. FIFOs cleared, FSM in IDLE.
- Synchronisers:
  - cs, sclk and mosi each pass through a 2-flop synchroniser.
  - Edge detection (rise/fall) runs on the synchronised sclk and cs, using one extra register each.
- FSM states: IDLE, SHIFT, ABORT.
- IDLE:
  - miso=0, bit counter=0.
  - On cs falling edge: pop the TX FIFO if non-empty, otherwise use FILL_WORD.
  - Load the TX shift register, drive miso=word[15], go to SHIFT.
  - miso MSB is valid ≤4 clk after the raw cs falls.
- SHIFT, sclk rising edge:
  - Shift the synced mosi into the RX shift register LSB; bit counter +1.
  - On the 16th rising edge (counter 15→0):
    - Next cycle: write the assembled word into the RX FIFO. If the RX FIFO is full, drop the word and set overflow.
    - Same edge: prefetch the next TX word (pop if non-empty, otherwise FILL_WORD) into a holding register.
- SHIFT, sclk falling edge:
  - Inside a word: shift the TX register left; miso = next bit.
  - After a completed word: load the holding register; miso = its MSB. This makes back-to-back words within one cs-low frame continuous.
  - A prefetched word that is never shifted out (cs rises first) is discarded, not returned to the FIFO.
- SHIFT, cs rising edge:
  - Counter=0 (word boundary): go to IDLE, no error.
  - Counter≠0: partial RX word discarded, frame_err pulses 1 clk, go to ABORT.
- ABORT: one cycle, then IDLE. A cs fall during ABORT is honoured the next cycle.
- Simultaneous events:
  - cs rising and sclk edge in the same clk: cs wins; the sclk edge is ignored.
  - RX FIFO write and rd_req in the same cycle: both occur; len unchanged.
  - TX pop and in_ena in the same cycle: both occur.
  - in_ena while tx_full: write ignored.
  - rd_req while empty: ignored; out_data holds.
- len: 0..RX_DEPTH, registered, updates the cycle after a write or read.
- overflow: cleared only by reset.
- Reset mid-frame: immediate return to IDLE with miso=0. The master's frame is lost; the slave resyncs on the next cs fall.

Test Plan:
1. Enqueue TX 16'hA55A; master sends 16'h1234 in mode 0 at f_clk/12 → miso bits = A55A MSB-first; after cs rises, have_msg=1, len=1; rd_req → out_data=16'h1234 next cycle.
2. TX FIFO empty; master sends 16'hFFFF → miso all 0 (FILL_WORD); RX holds 16'hFFFF.
3. Enqueue 16'h0001, 16'h8000; one cs-low frame of 32 sclk with MOSI 16'hBEEF, 16'hCAFE → miso 0001 then 8000 with no gap; len=2; reads return BEEF then CAFE.
4. cs rises after 9 sclk → frame_err pulses once; len unchanged; next full word is received correctly.
5. Fill RX with 128 words, send one more (16'h7777) → len=128, overflow=1, 16'h7777 absent; reads return the first 128 words in order.
6. Assert n_rst after 5 bits of a word → all outputs 0 and FIFOs empty; after release, a full 16'h5A5A word is received correctly.
